uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

UART receiver with an output FIFO. It consumes the serial transmit line of an SSBCC processor such as the `o_UART_Tx` output of the hello-world design, and turns 8N1 frames back into bytes. The bytes are buffered in a first-word-fall-through FIFO behind a valid/ready interface, for checking in a bench or for use as a processor inport.

## Interface
- `G_CLK_FREQ_HZ`, default 100_000_000: i_clk frequency.
- `G_BAUD`, default 115200: line rate.
  - C_DIV = (G_CLK_FREQ_HZ + G_BAUD/2) / G_BAUD, which is 868 at the defaults.
  - C_HALF = C_DIV / 2, which is 434.
- `G_FIFO_DEPTH`, default 16: FIFO entries. Must be a power of 2, at least 2.
- `i_clk`, input, 1: processor clock.
- `i_rst`, input, 1: reset, asynchronous and active-high.
- `i_UART_Rx`, input, 1: serial line, idle high, asynchronous to i_clk.
- `o_data`, output, 8: head-of-FIFO byte. Valid only while o_data_valid is high.
- `o_data_valid`, output, 1: FIFO not empty.
- `i_data_ready`, input, 1: consumer accepts o_data. A pop happens on a cycle where o_data_valid and i_data_ready are both high.
- `o_framing_error`, output, 1: one-cycle pulse when a stop bit is sampled low.
- `o_overflow`, output, 1: one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- **Input synchronizer:** i_UART_Rx passes through a 2-flop synchronizer; both flops reset to 1. The synchronized value is called rx_s.
- **State machine:** states are WAIT_IDLE, IDLE, START, DATA and STOP. It uses a bit-timer counter and a bit-index counter of 0..7.
- **WAIT_IDLE:** this is the reset state. Go to IDLE on the first cycle rx_s = 1.
- **IDLE:** when rx_s = 0, go to START and load the timer with C_HALF-1.
- **START:** when the timer expires, check rx_s.
  - rx_s = 0: go to DATA, load the timer with C_DIV-1, set bit index to 0.
  - rx_s = 1: treat as a glitch and return to IDLE with no output.
- **DATA:** on each timer expiry, shift rx_s into the shift register LSB-first and reload the timer with C_DIV-1. After bit 7, go to STOP.
- **STOP:** on timer expiry, check rx_s.
  - rx_s = 1: push the byte into the FIFO and go to IDLE.
  - rx_s = 0: pulse o_framing_error, discard the byte and go to WAIT_IDLE. This also covers a line break.
- **FIFO:** G_FIFO_DEPTH entries with binary read/write pointers one bit wider than log2(depth).
  - Empty when the pointers are equal. Full when they differ only in the MSB.
  - Pointers wrap modulo 2·depth.
- **Push when full:**
  - If a pop occurs in the same cycle, the push is accepted and the FIFO stays full.
  - Otherwise the byte is dropped and o_overflow pulses.
- **Push and pop together when not full or empty:** both take effect and the count is unchanged.
- **Pop when empty:** ignored, since o_data_valid is low.
- **Reset behaviour:** i_rst asserted at any time, including mid-frame, immediately sets:
  - state to WAIT_IDLE;
  - FIFO empty;
  - o_data_valid = 0, o_data = 0x00;
  - o_framing_error = 0, o_overflow = 0;
  - synchronizer flops to 1.

  A frame in progress is abandoned. No false start is taken if the line is low after reset is released.

## Timing
- Let T0 be the first cycle rx_s = 0 while in IDLE. The start bit is sampled at T0 + C_HALF, which is mid-bit.
- Data bit k is sampled at T0 + C_HALF + (k+1)·C_DIV. The stop bit is sampled at T0 + C_HALF + 9·C_DIV.
- The byte appears on o_data with o_data_valid = 1 one cycle after the stop-bit sample cycle, provided the FIFO was empty.
- o_framing_error and o_overflow assert in the cycle after the stop-bit sample and last exactly 1 cycle.
- **Back-to-back frames:** the receiver is in IDLE 1 cycle after the stop-bit sample, about half a bit before the next start edge. Continuous back-to-back frames are received without loss.
- **Pop timing:** o_data and o_data_valid update in the cycle after a pop. FIFO read has zero added latency (first-word-fall-through).
- **Tolerance:** baud mismatch up to ±3% must decode correctly.

## Test plan
- **Single byte:** reset for 5 cycles, then drive 0x48 ('H') at 115200 baud with i_data_ready = 1. Expect:
  - o_data = 0x48 with o_data_valid high for exactly 1 cycle;
  - valid rises at T0 + 434 + 9·868 + 1;
  - no error pulses.
- **Back-to-back string:** send "Hello World!\r\n" (14 bytes) back-to-back with zero idle bits and ready high. Expect all 14 bytes popped in order, with no framing error or overflow.
- **Glitch and framing error:**
  - A 200-cycle low pulse gives no byte and no error.
  - A frame of 0xA5 with the stop bit driven 0 gives one o_framing_error pulse and no push.
  - A following good 0x3C is then received correctly once the line has returned high.
- **Overflow:** hold i_data_ready = 0 and send 17 bytes 0x00..0x10.
  - o_overflow pulses once, on byte 0x10.
  - Releasing ready then pops 0x00..0x0F in order, after which valid drops.
- **Simultaneous push and pop:** with the FIFO full and ready asserted exactly on the push cycle, the new byte is kept and there is no overflow pulse.
- **Reset mid-frame:** assert i_rst at data bit 3 of a frame. Expect:
  - outputs go to 0 immediately;
  - no byte is emitted for the interrupted frame;
  - the next full frame, 0x5A, is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// ------------
// 8N1 UART receiver feeding a first-word-fall-through FIFO behind a
// valid/ready interface. The bit timer is derived from the clock frequency
// and baud generics. Each bit is sampled once at its centre: the start bit
// half a bit after the falling edge, and every later bit one bit period
// after the previous sample.
//
// Ports
//   i_clk            processor clock
//   i_rst            asynchronous, active-high reset
//   i_UART_Rx        serial line (idle high, asynchronous to i_clk)
//   o_data[7:0]      head-of-FIFO byte (0x00 while empty)
//   o_data_valid     FIFO not empty
//   i_data_ready     consumer accepts o_data (pop when valid & ready)
//   o_framing_error  1-cycle pulse when a stop bit is sampled low
//   o_overflow       1-cycle pulse when a good byte is dropped (FIFO full)
//
// G_FIFO_DEPTH must be a power of two and at least 2.

module uart_rx_fifo #(
  parameter int G_CLK_FREQ_HZ = 100_000_000,
  parameter int G_BAUD        = 115200,
  parameter int G_FIFO_DEPTH  = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_UART_Rx,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  input  logic       i_data_ready,
  output logic       o_framing_error,
  output logic       o_overflow
);

  localparam int C_DIV  = (G_CLK_FREQ_HZ + G_BAUD / 2) / G_BAUD;
  localparam int C_HALF = C_DIV / 2;
  localparam int TW     = $clog2(C_DIV);
  localparam int AW     = $clog2(G_FIFO_DEPTH);

  localparam logic [TW-1:0] C_DIV_M1  = TW'(C_DIV - 1);
  localparam logic [TW-1:0] C_HALF_M1 = TW'(C_HALF - 1);
  localparam logic [TW-1:0] T_ONE     = TW'(1);

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } state_t;

  // --------------------------------------------------------------------
  // Input synchronizer
  // --------------------------------------------------------------------
  logic       rx_meta_q;
  logic       rx_s_q;
  // The synchronizer resets to 1, which is not a real observation of the
  // line. prime_q fills with ones as the real line value reaches rx_s_q,
  // so a line held low through reset release is not mistaken for an
  // idle-then-start sequence.
  logic [1:0] prime_q;
  logic       rx_ok;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      prime_q   <= 2'b00;
    end else begin
      rx_meta_q <= i_UART_Rx;
      rx_s_q    <= rx_meta_q;
      prime_q   <= {prime_q[0], 1'b1};
    end
  end

  assign rx_ok = prime_q[1];

  // --------------------------------------------------------------------
  // Receiver FSM
  // --------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q,   bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tick;
  logic          push_req;
  logic          frame_err;

  assign tick = (timer_q == '0);

  // State register (with the timer, bit index and shift register).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= WAIT_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      WAIT_IDLE: begin
        if (rx_ok && rx_s_q) state_d = IDLE;
      end
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          timer_d = C_HALF_M1;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s_q) begin
            state_d = DATA;
            timer_d = C_DIV_M1;
            bit_d   = 3'd0;
          end else begin
            // Line back high at mid start bit: a glitch, not a frame.
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {rx_s_q, shift_q[7:1]};  // LSB arrives first
          timer_d = C_DIV_M1;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      STOP: begin
        if (tick) begin
          // A low stop bit (framing error or break) must see the line
          // return high before another start edge is accepted.
          state_d = rx_s_q ? IDLE : WAIT_IDLE;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    push_req  = 1'b0;
    frame_err = 1'b0;
    if (state_q == STOP && tick) begin
      push_req  = rx_s_q;
      frame_err = !rx_s_q;
    end
  end

  // --------------------------------------------------------------------
  // FWFT FIFO
  // --------------------------------------------------------------------
  // Pointers carry one extra wrap bit: equal means empty, equal except
  // for the wrap bit means full.
  logic [7:0]  mem_q [G_FIFO_DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        empty, full;
  logic        pop, push, drop;
  logic        ferr_q, ovf_q;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign pop  = !empty && i_data_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push = push_req && (!full || pop);
  assign drop = push_req && full && !pop;

  assign wptr_d = wptr_q + (AW+1)'(push);
  assign rptr_d = rptr_q + (AW+1)'(pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ferr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ferr_q <= frame_err;
      ovf_q  <= drop;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= shift_q;
  end

  assign o_data          = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
  assign o_data_valid    = !empty;
  assign o_framing_error = ferr_q;
  assign o_overflow      = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int CLK_HZ = 5_000_000;
  localparam int BAUD   = 100_000;
  localparam int DEPTH  = 16;
  localparam int C_DIV  = (CLK_HZ + BAUD / 2) / BAUD;  // 50
  localparam int C_HALF = C_DIV / 2;                   // 25
  // Line edge to stop-bit sample: 2 synchronizer cycles + half bit + 9 bits.
  localparam int STOP_OFS = 2 + C_HALF + 9 * C_DIV;    // 477

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid, fe, ovf;

  uart_rx_fifo #(
    .G_CLK_FREQ_HZ(CLK_HZ),
    .G_BAUD       (BAUD),
    .G_FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_UART_Rx      (rx),
    .o_data         (data),
    .o_data_valid   (valid),
    .i_data_ready   (ready),
    .o_framing_error(fe),
    .o_overflow     (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] q[$];          // expected FIFO contents, head first
  logic [7:0] push_at[int];  // stop-sample cycle -> good byte
  bit         fe_at[int];    // stop-sample cycle of a bad frame
  bit         fe_exp[int];   // cycles where o_framing_error must be high
  bit         ovf_exp[int];  // cycles where o_overflow must be high

  task automatic model_clear();
    q.delete();
    push_at.delete();
    fe_at.delete();
    fe_exp.delete();
    ovf_exp.delete();
  endtask

  // Compare this cycle, then advance the model across the next edge.
  always @(negedge clk) begin : cmp
    bit pop_m;
    if (!rst) begin
      chk("valid", valid, q.size() != 0);
      if (q.size() != 0) chk("data", data, q[0]);
      chk("framing_error", fe, fe_exp.exists(cyc));
      chk("overflow", ovf, ovf_exp.exists(cyc));
      pop_m = (q.size() != 0) && ready;
      if (pop_m) void'(q.pop_front());
      if (push_at.exists(cyc)) begin
        if (q.size() < DEPTH) q.push_back(push_at[cyc]);
        else                  ovf_exp[cyc + 1] = 1'b1;
      end
      if (fe_at.exists(cyc)) fe_exp[cyc + 1] = 1'b1;
    end
  end

  // ---------------- observation for literal checks ----------------
  int         rise_cyc, valid_cnt, fe_cnt, ovf_cnt, ovf_cyc;
  logic [7:0] rise_data;
  logic [7:0] got[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        if (rise_cyc < 0) begin
          rise_cyc  = cyc;
          rise_data = data;
        end
        valid_cnt++;
        if (ready) got.push_back(data);
      end
      if (fe) fe_cnt++;
      if (ovf) begin
        ovf_cnt++;
        ovf_cyc = cyc;
      end
    end
  end

  task automatic clr_mon();
    rise_cyc  = -1;
    valid_cnt = 0;
    fe_cnt    = 0;
    ovf_cnt   = 0;
    ovf_cyc   = -1;
    got.delete();
  endtask

  // ---------------- stimulus ----------------
  int last_c;
  bit rand_ready = 1'b0;

  // All tasks start and end one time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int period,
                            input bit stop_bit, input bit good);
    logic [9:0] bits;
    int c;
    bits   = {stop_bit, b, 1'b0};
    c      = cyc;
    last_c = c;
    if (good)           push_at[c + STOP_OFS] = b;
    else if (!stop_bit) fe_at[c + STOP_OFS]   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      idle(period);
    end
    rx = 1'b1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    model_clear();
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_fe", fe, 0);
    chk("rst_ovf", ovf, 0);
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) ready = 1'($urandom_range(0, 1));
    end
  end

  logic [7:0] msg [14] = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20, 8'h57,
                           8'h6f, 8'h72, 8'h6c, 8'h64, 8'h21, 8'h0d, 8'h0a};

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    ready = 1'b1;
    clr_mon();
    repeat (5) @(posedge clk);
    #1;
    chk("reset_valid", valid, 0);
    chk("reset_data", data, 0);
    chk("reset_fe", fe, 0);
    chk("reset_ovf", ovf, 0);
    rst = 1'b0;
    idle(10);

    // Single byte: valid rises 2 + 25 + 9*50 + 1 = 478 cycles after the edge.
    clr_mon();
    send_frame(8'h48, C_DIV, 1'b1, 1'b1);
    idle(20);
    chk("single_rise_cycle", rise_cyc, last_c + 478);
    chk("single_data", rise_data, 8'h48);
    chk("single_valid_cycles", valid_cnt, 1);
    chk("single_fe", fe_cnt, 0);
    chk("single_ovf", ovf_cnt, 0);

    // Back-to-back string.
    clr_mon();
    for (int i = 0; i < 14; i++) send_frame(msg[i], C_DIV, 1'b1, 1'b1);
    idle(40);
    chk("string_count", got.size(), 14);
    for (int i = 0; i < 14 && i < got.size(); i++) chk("string_byte", got[i], msg[i]);
    chk("string_fe", fe_cnt, 0);
    chk("string_ovf", ovf_cnt, 0);

    // Short low glitch.
    clr_mon();
    rx = 1'b0;
    idle(10);
    rx = 1'b1;
    idle(100);
    chk("glitch_valid", valid_cnt, 0);
    chk("glitch_fe", fe_cnt, 0);

    // Framing error, then a good byte.
    send_frame(8'hA5, C_DIV, 1'b0, 1'b0);
    idle(60);
    chk("framing_fe_pulses", fe_cnt, 1);
    chk("framing_no_byte", valid_cnt, 0);
    clr_mon();
    send_frame(8'h3C, C_DIV, 1'b1, 1'b1);
    idle(20);
    chk("after_fe_count", got.size(), 1);
    if (got.size() == 1) chk("after_fe_byte", got[0], 8'h3C);

    // Overflow on the 17th byte.
    clr_mon();
    ready = 1'b0;
    for (int i = 0; i <= 16; i++) send_frame(8'(i), C_DIV, 1'b1, 1'b1);
    idle(20);
    chk("ovf_pulses", ovf_cnt, 1);
    chk("ovf_cycle", ovf_cyc, last_c + 478);
    chk("ovf_full_valid", valid, 1);
    ready = 1'b1;
    idle(30);
    chk("ovf_drain_count", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++) chk("ovf_drain_byte", got[i], i);
    chk("ovf_drained_valid", valid, 0);

    // Full FIFO, ready asserted exactly on the push cycle.
    clr_mon();
    ready = 1'b0;
    for (int i = 0; i < 16; i++) send_frame(8'h80 + 8'(i), C_DIV, 1'b1, 1'b1);
    fork
      send_frame(8'h90, C_DIV, 1'b1, 1'b1);
      begin
        idle(STOP_OFS);
        ready = 1'b1;
        idle(1);
        ready = 1'b0;
      end
    join
    idle(20);
    chk("simul_ovf", ovf_cnt, 0);
    chk("simul_one_pop", got.size(), 1);
    ready = 1'b1;
    idle(30);
    chk("simul_drain_count", got.size(), 17);
    for (int i = 0; i < 17 && i < got.size(); i++) chk("simul_byte", got[i], 8'h80 + i);

    // Reset at data bit 3 with a byte waiting in the FIFO.
    clr_mon();
    ready = 1'b0;
    send_frame(8'h11, C_DIV, 1'b1, 1'b1);
    idle(10);
    chk("pre_reset_valid", valid, 1);
    fork
      send_frame(8'hF8, C_DIV, 1'b1, 1'b1);
      begin
        idle(4 * C_DIV + C_DIV / 2);
        do_reset(3);
      end
    join
    clr_mon();
    ready = 1'b1;
    idle(100);
    chk("midrst_no_byte", valid_cnt, 0);
    chk("midrst_no_fe", fe_cnt, 0);
    send_frame(8'h5A, C_DIV, 1'b1, 1'b1);
    idle(20);
    chk("midrst_next_count", got.size(), 1);
    if (got.size() == 1) chk("midrst_next_byte", got[0], 8'h5A);

    // Line held low across reset release: no false start.
    clr_mon();
    rst = 1'b1;
    rx = 1'b0;
    model_clear();
    idle(3);
    rst = 1'b0;
    idle(150);
    rx = 1'b1;
    idle(60);
    chk("lowrst_fe", fe_cnt, 0);
    chk("lowrst_valid", valid_cnt, 0);

    // Baud mismatch of about +-2%.
    clr_mon();
    send_frame(8'h55, C_DIV - 1, 1'b1, 1'b1);
    send_frame(8'hAA, C_DIV + 1, 1'b1, 1'b1);
    send_frame(8'h0F, C_DIV - 1, 1'b1, 1'b1);
    send_frame(8'hF0, C_DIV + 1, 1'b1, 1'b1);
    idle(20);
    chk("tol_count", got.size(), 4);

    // Random bytes, gaps, rates and ready.
    clr_mon();
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      idle(int'($urandom_range(0, 120)));
      send_frame(8'($urandom), C_DIV - 1 + int'($urandom_range(0, 2)), 1'b1, 1'b1);
    end
    idle(20);
    rand_ready = 1'b0;
    ready = 1'b1;
    idle(40);
    chk("rand_count", got.size(), 20);
    chk("rand_ovf", ovf_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
